axi4lite_reg_slave: RTL

Synthesizable AXI4-Lite responder that exposes a bank of NUM_REGS data-width registers to an AXI4-Lite initiator, such as the Axi4LiteMaster bench driver. It has independent read and write channel FSMs, per-byte write strobes and DECERR for addresses outside its window. Register contents drive fabric control logic through REG_OUT, and each accepted write produces a one-cycle per-register pulse.

---
 rtl/axi4lite_reg_slave_if.sv | 43 ++++
 rtl/axi4lite_reg_slave.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_reg_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_reg_slave_if
// Brief    : AXI4-Lite bus bundle between an initiator and the register slave.
// Revision : 1.0
// ============================================================================
interface axi4lite_reg_slave_if #(
  parameter int N      = 4,
  parameter int ADDR_W = 32
);
  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                wvalid;
  logic                wready;
  logic [8*N-1:0]      wdata;
  logic [N-1:0]        wstrb;
  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                rvalid;
  logic                rready;
  logic [8*N-1:0]      rdata;
  logic [1:0]          rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface
`default_nettype wire

// File: rtl/axi4lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_reg_slave
// Brief    : AXI4-Lite register bank with independent read/write FSMs,
//            byte strobes, DECERR outside the window and per-register pulses.
// Revision : 1.0
// ============================================================================
module axi4lite_reg_slave #(
  parameter int                N         = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                NUM_REGS  = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  axi4lite_reg_slave_if.slave      s,
  output logic [NUM_REGS*8*N-1:0]  reg_out,
  output logic [NUM_REGS-1:0]      wr_pulse
);
  localparam int              c_DATA   = 8 * N;
  localparam int              c_LSB    = $clog2(N);
  localparam int              c_IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] c_WIN    = (ADDR_W+1)'(NUM_REGS * N);
  localparam logic [1:0]      c_OKAY   = 2'b00;
  localparam logic [1:0]      c_DECERR = 2'b11;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic [c_DATA-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_pulse;

  logic                r_aw_held, r_w_held;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [c_DATA-1:0]   r_wdata;
  logic [N-1:0]        r_wstrb;
  logic [1:0]          r_bresp;
  logic [c_DATA-1:0]   r_rdata;
  logic [1:0]          r_rresp;

  logic                w_awready, w_wready, w_arready, w_bvalid, w_rvalid;
  logic                w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_W-1:0]   w_awaddr_eff, w_woff, w_roff;
  logic [c_DATA-1:0]   w_wdata_eff;
  logic [N-1:0]        w_wstrb_eff;
  logic                w_win, w_rwin;
  logic [c_IDX_W-1:0]  w_widx, w_ridx;
  logic                w_unused;

  // Readies depend only on registered state so no VALID->READY path exists.
  assign w_awready = (r_wstate == W_IDLE) && !r_aw_held && !areset;
  assign w_wready  = (r_wstate == W_IDLE) && !r_w_held  && !areset;
  assign w_arready = (r_rstate == R_IDLE) && !areset;

  assign w_aw_hs = s.awvalid && w_awready;
  assign w_w_hs  = s.wvalid  && w_wready;
  assign w_ar_hs = s.arvalid && w_arready;

  assign w_awaddr_eff = r_aw_held ? r_awaddr : s.awaddr;
  assign w_wdata_eff  = r_w_held  ? r_wdata  : s.wdata;
  assign w_wstrb_eff  = r_w_held  ? r_wstrb  : s.wstrb;
  assign w_commit     = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  // Offsets wrap modulo 2^ADDR_W, so addresses below BASE_ADDR land out of range.
  assign w_woff = w_awaddr_eff - BASE_ADDR;
  assign w_roff = s.araddr - BASE_ADDR;
  assign w_win  = {1'b0, w_woff} < c_WIN;
  assign w_rwin = {1'b0, w_roff} < c_WIN;
  assign w_widx = w_woff[c_LSB +: c_IDX_W];
  assign w_ridx = w_roff[c_LSB +: c_IDX_W];

  assign w_unused = ^{s.awprot, s.arprot, w_woff, w_roff};

  // ---------------- write channel ----------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_bvalid     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_commit) begin
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (s.bready) begin
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= c_OKAY;
    end else if (r_wstate == W_RESP) begin
      if (s.bready) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s.awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s.wdata;
        r_wstrb  <= s.wstrb;
      end
      if (w_commit) begin
        r_bresp <= w_win ? c_OKAY : c_DECERR;
      end
    end
  end

  // Register bank; the pulse fires even for an all-zero strobe.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit && w_win) begin
        r_wr_pulse[w_widx] <= 1'b1;
        for (int k = 0; k < N; k++) begin
          if (w_wstrb_eff[k]) begin
            r_regs[w_widx][8*k +: 8] <= w_wdata_eff[8*k +: 8];
          end
        end
      end
    end
  end

  // ---------------- read channel ----------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rvalid     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rstate_nxt = R_DATA;
        end
      end
      R_DATA: begin
        w_rvalid = 1'b1;
        if (s.rready) begin
          w_rstate_nxt = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Sampling r_regs here sees the pre-commit value on a same-edge write.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rdata <= '0;
      r_rresp <= c_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rwin ? r_regs[w_ridx] : '0;
      r_rresp <= w_rwin ? c_OKAY : c_DECERR;
    end
  end

  assign s.awready = w_awready;
  assign s.wready  = w_wready;
  assign s.bvalid  = w_bvalid;
  assign s.bresp   = r_bresp;
  assign s.arready = w_arready;
  assign s.rvalid  = w_rvalid;
  assign s.rdata   = r_rdata;
  assign s.rresp   = r_rresp;

  assign wr_pulse = r_wr_pulse;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign reg_out[i*c_DATA +: c_DATA] = r_regs[i];
  end

endmodule
`default_nettype wire
